// File: rtl/mips_mmio_pkg.sv
// Register map and bit positions shared by the MIPS MMIO bridge and its sub-blocks.
package mips_mmio_pkg;

  localparam logic [7:0] MMIO_LED    = 8'h00;
  localparam logic [7:0] MMIO_TX     = 8'h04;
  localparam logic [7:0] MMIO_STATUS = 8'h08;
  localparam logic [7:0] MMIO_TLOAD  = 8'h0C;
  localparam logic [7:0] MMIO_TCTRL  = 8'h10;
  localparam logic [7:0] MMIO_TVAL   = 8'h14;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_EXPIRED   = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int TC_ENABLE      = 0;
  localparam int TC_AUTO_RELOAD = 1;
  localparam int TC_IRQ_EN      = 2;
  localparam int TC_CLEAR       = 3;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte-wide transmit FIFO; no fall-through, full/empty taken from pre-edge state.
module mmio_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_mmio_bridge.sv
// Splits the core memory port between the unified RAM and local MMIO registers.
// Countdown timer is built only when MMIO_TIMER_EN is defined.
module mips_mmio_bridge
  import mips_mmio_pkg::*;
#(
  parameter logic [15:0] MMIO_BASE  = 16'hFFFF,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wr_data,
  input  logic        cpu_wr_ena,
  output logic [31:0] cpu_rd_data,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wr_data,
  output logic        ram_wr_ena,
  input  logic [31:0] ram_rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  led,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          is_mmio, mmio_wr, push, pop;
  logic [7:0]    offset, led_q;
  logic          ovf, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   tload, tval, rd_mux, mmio_rd_q;
  logic [2:0]    tctrl;
  logic          expired, sel_q;

  assign is_mmio     = (cpu_addr[31:16] == MMIO_BASE);
  assign offset      = cpu_addr[7:0];
  assign mmio_wr     = cpu_wr_ena & is_mmio;
  assign ram_addr    = cpu_addr;
  assign ram_wr_data = cpu_wr_data;
  assign ram_wr_ena  = cpu_wr_ena & ~is_mmio;
  assign push        = mmio_wr && (offset == MMIO_TX);
  assign pop         = tx_valid & tx_ready;
  assign tx_valid    = ~fifo_empty;
  assign led         = led_q;

  mmio_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rstb      (rstb),
    .push      (push),
    .push_data (cpu_wr_data[7:0]),
    .pop       (pop),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rstb) begin
      led_q <= '0;
      ovf   <= 1'b0;
    end else begin
      if (mmio_wr && offset == MMIO_LED) led_q <= cpu_wr_data[7:0];
      if (mmio_wr && offset == MMIO_STATUS) ovf <= 1'b0;
      else if (push && fifo_full) ovf <= 1'b1;
    end
  end

`ifdef MMIO_TIMER_EN
  // Expiry is assigned after the clear so a coincident expiry keeps expired set.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      tload   <= '0;
      tval    <= '0;
      tctrl   <= '0;
      expired <= 1'b0;
    end else begin
      if (mmio_wr && offset == MMIO_TCTRL) begin
        tctrl <= cpu_wr_data[2:0];
        if (cpu_wr_data[TC_CLEAR]) expired <= 1'b0;
      end
      if (mmio_wr && offset == MMIO_TLOAD) begin
        tload <= cpu_wr_data;
        tval  <= cpu_wr_data;
      end else if (tctrl[TC_ENABLE] && tval != '0) begin
        if (tval == 32'd1) begin
          expired <= 1'b1;
          tval    <= tctrl[TC_AUTO_RELOAD] ? tload : '0;
        end else begin
          tval <= tval - 32'd1;
        end
      end
    end
  end

  assign irq = expired & tctrl[TC_IRQ_EN];
`else
  assign tload   = '0;
  assign tval    = '0;
  assign tctrl   = '0;
  assign expired = 1'b0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    if (is_mmio) begin
      case (offset)
        MMIO_LED:    rd_mux = {24'b0, led_q};
        MMIO_STATUS: begin
          rd_mux[ST_FULL]             = fifo_full;
          rd_mux[ST_EMPTY]            = fifo_empty;
          rd_mux[ST_EXPIRED]          = expired;
          rd_mux[ST_OVF]              = ovf;
          rd_mux[ST_COUNT_LSB +: 4]   = 4'(fifo_count);
        end
        MMIO_TLOAD:  rd_mux = tload;
        MMIO_TCTRL:  rd_mux = {29'b0, tctrl};
        MMIO_TVAL:   rd_mux = tval;
        default:     rd_mux = '0;
      endcase
    end
  end

  // Registered alongside the RAM's synchronous read so both regions have one cycle of latency.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      sel_q     <= 1'b0;
      mmio_rd_q <= '0;
    end else begin
      sel_q     <= is_mmio;
      mmio_rd_q <= rd_mux;
    end
  end

  assign cpu_rd_data = sel_q ? mmio_rd_q : ram_rd_data;

endmodule

// File: tb/tb_mips_mmio_bridge.sv
// Directed self-checking bench for mips_mmio_bridge; timer checks follow MMIO_TIMER_EN.
module tb_mips_mmio_bridge;
  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] cpu_addr, cpu_wr_data, cpu_rd_data;
  logic        cpu_wr_ena;
  logic [31:0] ram_addr, ram_wr_data, ram_rd_data;
  logic        ram_wr_ena;
  logic [7:0]  tx_data, led;
  logic        tx_valid, tx_ready, irq;
  logic [31:0] rd;
  int          checks = 0;
  int          failures = 0;

  localparam logic [7:0] O_LED = 8'h00, O_TX = 8'h04, O_ST = 8'h08;
  localparam logic [7:0] O_TLOAD = 8'h0C, O_TCTRL = 8'h10, O_TVAL = 8'h14;

  mips_mmio_bridge #(.MMIO_BASE(16'hFFFF), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_wr_ena  (cpu_wr_ena),
    .cpu_rd_data (cpu_rd_data),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr_ena  (ram_wr_ena),
    .ram_rd_data (ram_rd_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .led         (led),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM stand-in with one known word and a recognisable fill pattern.
  always @(posedge clk)
    ram_rd_data <= (ram_addr == 32'h0040_0000) ? 32'h2008_0005 : (32'hDEAD_0000 ^ ram_addr);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_wr(input logic [7:0] off, input logic [31:0] d);
    cpu_addr    = {16'hFFFF, 8'h00, off};
    cpu_wr_data = d;
    cpu_wr_ena  = 1'b1;
    #1;
    chk("mmio_no_ram_wr", {31'b0, ram_wr_ena}, 32'd0);
    tick();
    cpu_wr_ena = 1'b0;
  endtask

  task automatic mmio_rd(input logic [7:0] off, output logic [31:0] d);
    cpu_addr   = {16'hFFFF, 8'h00, off};
    cpu_wr_ena = 1'b0;
    tick();
    d = cpu_rd_data;
  endtask

  task automatic drain(input string tag, input int first, input int n);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk(tag, {24'b0, tx_data}, 32'(first + i));
      tick();
    end
    tx_ready = 1'b0;
    chk({tag, "_empty"}, {31'b0, tx_valid}, 32'd0);
  endtask

  initial begin
    rstb        = 1'b0;
    cpu_addr    = 32'h0040_0000;
    cpu_wr_data = '0;
    cpu_wr_ena  = 1'b0;
    tx_ready    = 1'b0;
    tick();
    tick();
    chk("rst_led", {24'b0, led}, 32'd0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_rd_ram", cpu_rd_data, 32'h2008_0005);
    rstb = 1'b1;
    tick();
    chk("ram_read", cpu_rd_data, 32'h2008_0005);
    chk("ram_rd_no_wr", {31'b0, ram_wr_ena}, 32'd0);

    cpu_addr    = 32'h0040_0010;
    cpu_wr_data = 32'hCAFE_F00D;
    cpu_wr_ena  = 1'b1;
    #1;
    chk("ram_wr_ena", {31'b0, ram_wr_ena}, 32'd1);
    chk("ram_wr_data", ram_wr_data, 32'hCAFE_F00D);
    chk("ram_addr", ram_addr, 32'h0040_0010);
    cpu_wr_ena = 1'b0;
    tick();

    mmio_wr(O_LED, 32'h1234_56A5);
    chk("led", {24'b0, led}, 32'hA5);
    mmio_rd(O_LED, rd);
    chk("led_rd", rd, 32'h0000_00A5);

    for (int i = 1; i <= 9; i++) mmio_wr(O_TX, 32'(i));
    chk("fifo_valid", {31'b0, tx_valid}, 32'd1);
    chk("fifo_head", {24'b0, tx_data}, 32'd1);
    mmio_rd(O_ST, rd);
    chk("status_full_ovf", rd, 32'h809);
    mmio_rd(O_TX, rd);
    chk("tx_rd_zero", rd, 32'd0);
    mmio_wr(O_ST, 32'd0);
    mmio_rd(O_ST, rd);
    chk("status_ovf_clr", rd, 32'h801);
    drain("drain8", 1, 8);
    mmio_rd(O_ST, rd);
    chk("status_empty", rd, 32'h002);

    for (int i = 10; i <= 12; i++) mmio_wr(O_TX, 32'(i));
    tx_ready = 1'b1;
    mmio_wr(O_TX, 32'd13);
    tx_ready = 1'b0;
    mmio_rd(O_ST, rd);
    chk("status_pushpop", rd, 32'h300);
    drain("drain_pp", 11, 3);

    for (int i = 20; i <= 27; i++) mmio_wr(O_TX, 32'(i));
    tx_ready = 1'b1;
    mmio_wr(O_TX, 32'd99);
    tx_ready = 1'b0;
    mmio_rd(O_ST, rd);
    chk("status_full_pop", rd, 32'h708);
    drain("drain_full", 21, 7);
    mmio_wr(O_ST, 32'd0);

`ifdef MMIO_TIMER_EN
    mmio_wr(O_TLOAD, 32'd3);
    mmio_wr(O_TCTRL, 32'b101);
    chk("irq_c0", {31'b0, irq}, 32'd0);
    tick();
    chk("irq_c1", {31'b0, irq}, 32'd0);
    tick();
    chk("irq_c2", {31'b0, irq}, 32'd0);
    tick();
    chk("irq_c3", {31'b0, irq}, 32'd1);
    mmio_rd(O_TVAL, rd);
    chk("tval_zero", rd, 32'd0);
    mmio_rd(O_ST, rd);
    chk("status_expired", rd, 32'h006);
    mmio_rd(O_TCTRL, rd);
    chk("tctrl_rd", rd, 32'd5);
    mmio_wr(O_TCTRL, 32'hD);
    chk("irq_clr", {31'b0, irq}, 32'd0);
    mmio_rd(O_TCTRL, rd);
    chk("tctrl_bit3_rd", rd, 32'd5);
    mmio_rd(O_ST, rd);
    chk("status_exp_clr", rd, 32'h002);
    mmio_wr(O_TCTRL, 32'd0);

    mmio_wr(O_TLOAD, 32'd2);
    mmio_wr(O_TCTRL, 32'b011);
    cpu_addr = {16'hFFFF, 8'h00, O_TVAL};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tval_reload", cpu_rd_data, (i % 2 == 0) ? 32'd2 : 32'd1);
    end
    mmio_rd(O_ST, rd);
    chk("status_reload_exp", rd, 32'h006);
    mmio_wr(O_TCTRL, 32'hB);
    mmio_rd(O_ST, rd);
    chk("expiry_beats_clear", rd, 32'h006);
    mmio_rd(O_TCTRL, rd);
    chk("tctrl_auto_rd", rd, 32'd3);
`else
    mmio_wr(O_TLOAD, 32'd3);
    mmio_wr(O_TCTRL, 32'b101);
    tick();
    tick();
    tick();
    chk("irq_tied", {31'b0, irq}, 32'd0);
    mmio_rd(O_TLOAD, rd);
    chk("tload_absent", rd, 32'd0);
    mmio_rd(O_TCTRL, rd);
    chk("tctrl_absent", rd, 32'd0);
    mmio_rd(O_TVAL, rd);
    chk("tval_absent", rd, 32'd0);
    mmio_rd(O_ST, rd);
    chk("status_no_timer", rd, 32'h002);
`endif

    mmio_wr(O_TX, 32'h55);
    chk("pre_rst_valid", {31'b0, tx_valid}, 32'd1);
    cpu_addr = {16'hFFFF, 8'h00, O_LED};
    rstb = 1'b0;
    tick();
    chk("midrst_led", {24'b0, led}, 32'd0);
    chk("midrst_valid", {31'b0, tx_valid}, 32'd0);
    chk("midrst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("midrst_irq", {31'b0, irq}, 32'd0);
    chk("midrst_rd_ram", cpu_rd_data, 32'h2152_0000);
    rstb = 1'b1;
    mmio_rd(O_LED, rd);
    chk("post_rst_led", rd, 32'd0);
    mmio_rd(O_ST, rd);
    chk("post_rst_status", rd, 32'h002);
    mmio_rd(O_TLOAD, rd);
    chk("post_rst_tload", rd, 32'd0);
    mmio_rd(O_TCTRL, rd);
    chk("post_rst_tctrl", rd, 32'd0);
    mmio_rd(O_TVAL, rd);
    chk("post_rst_tval", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
